// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and constants for the fifo write-port arbiter.
package fifo_wr_arbiter_pkg;

    localparam int FIFO_WIDTH = 8;
    localparam int FIFO_DEPTH = 63;

    typedef enum logic {IDLE, HOLD} arb_state_t;
    typedef logic [FIFO_WIDTH-1:0] fifo_word_t;

    // Index increment modulo n.
    function automatic int wrap_inc(int v, int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer handshake and fifo write-side signals of the write-port arbiter.
interface fifo_wr_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = fifo_wr_arbiter_pkg::FIFO_WIDTH,
    parameter int DEPTH = fifo_wr_arbiter_pkg::FIFO_DEPTH
);
    localparam int IW = $clog2(NREQ);
    localparam int OW = $clog2(DEPTH + 1);

    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0][WIDTH-1:0] req_data;
    logic [NREQ-1:0]            req_ready;
    logic                       rd_en;
    logic                       empty;
    logic                       full;
    logic                       wr_en;
    logic [WIDTH-1:0]           data_in;
    logic [IW-1:0]              grant_id;
    logic [OW-1:0]              occ;
    logic                       overflow_err;

    modport master (
        input  req_valid, req_data, rd_en, empty, full,
        output req_ready, wr_en, data_in, grant_id, occ, overflow_err
    );

    modport slave (
        output req_valid, req_data, rd_en, empty, full,
        input  req_ready, wr_en, data_in, grant_id, occ, overflow_err
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating priority encoder: first set bit of req_i searching base_i, base_i+1, ... mod NREQ.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   base_i,
    output logic [IW-1:0]   idx_o,
    output logic            found_o
);
    always_comb begin
        int            s;
        logic [IW-1:0] c;
        idx_o   = '0;
        found_o = 1'b0;
        s       = 0;
        c       = '0;
        for (int k = 0; k < NREQ; k++) begin
            s = int'(base_i) + k;
            if (s >= NREQ) s = s - NREQ;
            c = IW'(s);
            if (!found_o && req_i[c]) begin
                idx_o   = c;
                found_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded arbiter for the single fifo write port, with a
// conservative occupancy count that blocks producers before the fifo can overrun.
module fifo_wr_arbiter import fifo_wr_arbiter_pkg::*; #(
    parameter int NREQ      = 4,
    parameter int WIDTH     = FIFO_WIDTH,
    parameter int DEPTH     = FIFO_DEPTH,
    parameter int MAX_BURST = 4
) (
    input logic              clk,
    input logic              rst,
    fifo_wr_arbiter_if.master bus
);
    localparam int IW = $clog2(NREQ);
    localparam int OW = $clog2(DEPTH + 1);
    localparam int BW = $clog2(MAX_BURST + 1);

    arb_state_t       state_q;
    logic [IW-1:0]    rr_ptr_q, owner_q, grant_q;
    logic [BW-1:0]    burst_cnt_q;
    logic [OW-1:0]    occ_q, occ_d;
    logic             wr_en_q, ovf_q;
    logic [WIDTH-1:0] data_q;

    logic [NREQ-1:0]  ready;
    logic [IW-1:0]    pick, sel, owner_inc, pick_inc;
    logic [BW-1:0]    burst_nxt;
    logic             found, space, accept, pop;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req_i  (bus.req_valid),
        .base_i (rr_ptr_q),
        .idx_o  (pick),
        .found_o(found)
    );

    assign space     = occ_q < OW'(DEPTH);
    assign pop       = bus.rd_en & ~bus.empty;
    assign accept    = |(bus.req_valid & ready);
    assign owner_inc = IW'(wrap_inc(int'(owner_q), NREQ));
    assign pick_inc  = IW'(wrap_inc(int'(pick), NREQ));
    assign burst_nxt = burst_cnt_q + BW'(1);

    // Ready is gated by reset so a word offered during reset is never taken.
    always_comb begin
        ready = '0;
        sel   = owner_q;
        if (rst) begin
            if (state_q == IDLE) begin
                sel = pick;
                if (found && space) ready[pick] = 1'b1;
            end else if (space && bus.req_valid[owner_q]) begin
                ready[owner_q] = 1'b1;
            end
        end
    end

    always_comb begin
        occ_d = occ_q;
        if (accept && !(pop && occ_q != '0)) begin
            if (occ_q != OW'(DEPTH)) occ_d = occ_q + OW'(1);
        end else if (!accept && pop && occ_q != '0) begin
            occ_d = occ_q - OW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            burst_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    if (MAX_BURST == 1) begin
                        rr_ptr_q <= pick_inc;
                    end else begin
                        owner_q     <= pick;
                        burst_cnt_q <= BW'(1);
                        state_q     <= HOLD;
                    end
                end
                HOLD: if (accept) begin
                    burst_cnt_q <= burst_nxt;
                    if (burst_nxt == BW'(MAX_BURST)) begin
                        rr_ptr_q <= owner_inc;
                        state_q  <= IDLE;
                    end
                end else if (!bus.req_valid[owner_q]) begin
                    rr_ptr_q <= owner_inc;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en_q <= 1'b0;
            data_q  <= '0;
            grant_q <= '0;
            occ_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wr_en_q <= accept;
            occ_q   <= occ_d;
            ovf_q   <= ovf_q | (wr_en_q & bus.full);
            if (accept) begin
                data_q  <= bus.req_data[sel];
                grant_q <= sel;
            end
        end
    end

    assign bus.req_ready    = ready;
    assign bus.wr_en        = wr_en_q;
    assign bus.data_in      = data_q;
    assign bus.grant_id     = grant_q;
    assign bus.occ          = occ_q;
    assign bus.overflow_err = ovf_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Cycle-level bench: directed scenarios plus random traffic against a behavioural model.
module tb_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int D  = 63;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NREQ(N), .WIDTH(W), .DEPTH(D)) bus ();

    fifo_wr_arbiter #(.NREQ(N), .WIDTH(W), .DEPTH(D), .MAX_BURST(MB)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // model state: arbitration, write path, occupancy, and the fifo itself
    bit m_hold, m_wr, m_ovf;
    int m_owner, m_taken, m_prio, m_occ, m_fifo, m_data, m_gid;

    int          obs_wr;
    int          last_rdy;
    logic [N-1:0][W-1:0] last_dat;
    int          grants[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hold = 0; m_wr = 0; m_ovf = 0;
        m_owner = 0; m_taken = 0; m_prio = 0; m_occ = 0; m_fifo = 0;
        m_data = 0; m_gid = 0;
    endtask

    function automatic int exp_ready(bit [N-1:0] v, bit r);
        int p;
        if (!r || m_occ >= D) return 0;
        if (m_hold) return v[m_owner] ? (1 << m_owner) : 0;
        for (int k = 0; k < N; k++) begin
            p = (m_prio + k) % N;
            if (v[p]) return 1 << p;
        end
        return 0;
    endfunction

    task automatic cycle(input bit [N-1:0] v, input bit rd, input bit r);
        int rdy, sel;
        bit acc, pop;
        logic [N-1:0][W-1:0] dat;
        @(negedge clk);
        rst = r;
        for (int i = 0; i < N; i++) dat[i] = W'($urandom);
        bus.req_valid = v;
        bus.req_data  = dat;
        bus.rd_en     = rd;
        bus.empty     = (m_fifo == 0);
        bus.full      = (m_fifo >= D);
        #1;
        rdy = exp_ready(v, r);
        chk("ready", 32'(bus.req_ready), rdy);
        last_rdy = 32'(bus.req_ready);
        last_dat = dat;
        acc = (rdy != 0);
        sel = 0;
        for (int i = 0; i < N; i++) if (rdy[i]) sel = i;
        pop = rd && (m_fifo != 0);
        @(posedge clk);
        #1;
        if (!r) begin
            model_reset();
        end else begin
            // the fifo sees the write registered on the previous cycle
            m_ovf  = m_ovf | (m_wr && m_fifo >= D);
            m_fifo = m_fifo + (m_wr ? 1 : 0) - (pop ? 1 : 0);
            if (m_fifo > D) m_fifo = D;
            m_wr = acc;
            if (acc) begin
                m_data = int'(dat[sel]);
                m_gid  = sel;
            end
            m_occ = m_occ + (acc ? 1 : 0) - ((pop && m_occ != 0) ? 1 : 0);
            if (m_occ > D) m_occ = D;
            if (!m_hold) begin
                if (acc) begin
                    if (MB == 1) m_prio = (sel + 1) % N;
                    else begin m_hold = 1; m_owner = sel; m_taken = 1; end
                end
            end else if (acc) begin
                m_taken++;
                if (m_taken == MB) begin m_hold = 0; m_prio = (m_owner + 1) % N; end
            end else if (!v[m_owner]) begin
                m_hold = 0;
                m_prio = (m_owner + 1) % N;
            end
        end
        chk("wr_en", 32'(bus.wr_en), 32'(m_wr));
        chk("data_in", 32'(bus.data_in), m_data);
        chk("grant_id", 32'(bus.grant_id), m_gid);
        chk("occ", 32'(bus.occ), m_occ);
        chk("overflow_err", 32'(bus.overflow_err), 32'(m_ovf));
        if (bus.wr_en === 1'b1) begin
            obs_wr++;
            grants.push_back(int'(bus.grant_id));
        end
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.rd_en     = 1'b0;
        bus.empty     = 1'b1;
        bus.full      = 1'b0;
        model_reset();

        // reset held with every producer offering a word
        repeat (3) cycle(4'hF, 1'b0, 1'b0);
        chk("rst_wr_en", 32'(bus.wr_en), 0);
        chk("rst_occ", 32'(bus.occ), 0);

        // release: producer 0 first, then bursts of MB per producer
        grants.delete();
        cycle(4'hF, 1'b0, 1'b1);
        chk("first_ready", last_rdy, 1);
        chk("first_data", 32'(bus.data_in), 32'(last_dat[0]));
        repeat (15) cycle(4'hF, 1'b0, 1'b1);
        for (int i = 0; i < 2 * MB; i++)
            chk("burst_seq", (i < grants.size()) ? grants[i] : -1, i / MB);

        // fill to capacity from producer 2 alone
        cycle(4'hF, 1'b0, 1'b0);
        obs_wr = 0;
        repeat (72) cycle(4'b0100, 1'b0, 1'b1);
        chk("fill_writes", obs_wr, D);
        chk("fill_occ", 32'(bus.occ), D);
        chk("fill_ready", last_rdy, 0);
        chk("fill_ovf", 32'(bus.overflow_err), 0);

        // pop at capacity, then accept and pop in the same cycle
        cycle(4'b0100, 1'b1, 1'b1);
        chk("pop_occ", 32'(bus.occ), D - 1);
        cycle(4'b0100, 1'b1, 1'b1);
        chk("acc_pop_occ", 32'(bus.occ), D - 1);
        cycle(4'b0100, 1'b0, 1'b1);
        chk("refill_occ", 32'(bus.occ), D);

        // owner 1 drops valid after two words; producer 3 is next
        cycle(4'h0, 1'b0, 1'b0);
        repeat (2) cycle(4'b0010, 1'b0, 1'b1);
        cycle(4'b1000, 1'b0, 1'b1);
        chk("drop_gap", 32'(bus.wr_en), 0);
        cycle(4'b1000, 1'b0, 1'b1);
        chk("drop_gid", 32'(bus.grant_id), 3);

        // reset asserted in a cycle that would accept
        cycle(4'hF, 1'b0, 1'b1);
        cycle(4'hF, 1'b0, 1'b0);
        chk("midrst_wr_en", 32'(bus.wr_en), 0);
        chk("midrst_occ", 32'(bus.occ), 0);

        // random traffic with occasional resets
        for (int t = 0; t < 600; t++)
            cycle(N'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 150) != 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
